// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter: default widths, the write request
// record and the grant selector.
package wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 4;
  localparam int unsigned WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_ALU,
    GNT_BUF,
    GNT_STARVE
  } wb_gnt_e;

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer: in-order ring of {addr, data} entries with a per-slot
// valid mask exported so the arbiter can build its pending-register vector.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned AW    = WB_ADDR_WIDTH,
  parameter int unsigned DW    = WB_DATA_WIDTH,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      push_i,
  input  logic [AW-1:0]             push_addr_i,
  input  logic [DW-1:0]             push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [CW-1:0]             count_o,
  output logic [AW-1:0]             head_addr_o,
  output logic [DW-1:0]             head_data_o,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr_o,
  output logic [DEPTH-1:0]          ent_valid_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         valid_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign ent_addr_o  = addr_q;
  assign ent_valid_o = valid_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Push and pop never address the same slot: pop needs non-empty, push needs non-full.
      if (do_push) begin
        addr_q[wr_ptr_q]  <= push_addr_i;
        data_q[wr_ptr_q]  <= push_data_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Register-file write-back arbiter: ALU results win the single write slot,
// loads go through wb_fifo and are forced through after STARVE_MAX lost cycles.
// Optional WB_BYPASS_EN adds byp_* forwarding outputs mirroring the write port.
module wb_arb
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              alu_valid,
  input  logic [ADDR_WIDTH-1:0]             alu_addr,
  input  logic [DATA_WIDTH-1:0]             alu_data,
  output logic                              alu_ready,
  input  logic                              ld_valid,
  input  logic [ADDR_WIDTH-1:0]             ld_addr,
  input  logic [DATA_WIDTH-1:0]             ld_data,
  output logic                              ld_ready,
  output logic                              WrEn,
  output logic [ADDR_WIDTH-1:0]             WrAddr,
  output logic [DATA_WIDTH-1:0]             WrData,
  output logic [2**ADDR_WIDTH-1:0]          pending,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt
`ifdef WB_BYPASS_EN
  ,
  output logic                              byp_valid,
  output logic [ADDR_WIDTH-1:0]             byp_addr,
  output logic [DATA_WIDTH-1:0]             byp_data
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic                                 full, empty, push, pop, starve;
  logic [CW-1:0]                        cnt;
  logic [ADDR_WIDTH-1:0]                head_addr, sel_addr;
  logic [DATA_WIDTH-1:0]                head_data, sel_data;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
  logic [FIFO_DEPTH-1:0]                ent_valid;
  wb_gnt_e                              gnt;
  logic [SW-1:0]                        scnt_q, scnt_d;
  logic                                 wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]                wr_addr_q;
  logic [DATA_WIDTH-1:0]                wr_data_q;

  wb_fifo #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .push_i      (push),
    .push_addr_i (ld_addr),
    .push_data_i (ld_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (cnt),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .ent_addr_o  (ent_addr),
    .ent_valid_o (ent_valid)
  );

  assign ld_ready  = !full;
  assign push      = ld_valid && ld_ready;
  assign fifo_cnt  = cnt;
  assign starve    = !empty && (scnt_q >= SW'(STARVE_MAX));
  assign alu_ready = !starve;

  always_comb begin
    gnt = GNT_IDLE;
    if (starve)         gnt = GNT_STARVE;
    else if (alu_valid) gnt = GNT_ALU;
    else if (!empty)    gnt = GNT_BUF;
  end

  assign pop      = (gnt == GNT_STARVE) || (gnt == GNT_BUF);
  assign sel_addr = pop ? head_addr : alu_addr;
  assign sel_data = pop ? head_data : alu_data;
  // Register 0 is hardwired: the grant is still consumed, only the write is dropped.
  assign wr_en_d  = (gnt != GNT_IDLE) && (sel_addr != '0);

  always_comb begin
    scnt_d = scnt_q;
    if (pop)                                         scnt_d = '0;
    else if (!empty && (scnt_q < SW'(STARVE_MAX)))   scnt_d = scnt_q + 1'b1;
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pending[ent_addr[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      scnt_q  <= scnt_d;
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign WrEn   = wr_en_q;
  assign WrAddr = wr_addr_q;
  assign WrData = wr_data_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = wr_en_q;
  assign byp_addr  = wr_addr_q;
  assign byp_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: per-cycle vector table plus hand sequences for
// starvation override and reset mid-operation.
module tb_wb_arb;
  import wb_pkg::*;

  logic        clk, rstn;
  logic        alu_valid, ld_valid;
  logic [3:0]  alu_addr, ld_addr;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, WrEn;
  logic [3:0]  WrAddr;
  logic [31:0] WrData;
  logic [15:0] pending;
  logic [1:0]  fifo_cnt;

  int total = 0;
  int bad   = 0;

  wb_arb #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (2),
    .STARVE_MAX (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .pending   (pending),
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        alu_v;
    wb_req_t     alu;
    logic        ld_v;
    wb_req_t     ld;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    wb_req_t     e_wr;
    logic [15:0] e_pend;
    logic [1:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic av, logic [3:0] aa, logic [31:0] ad,
                              logic lv, logic [3:0] la, logic [31:0] ldd,
                              logic ear, logic elr, logic ewe,
                              logic [3:0] wa, logic [31:0] wd,
                              logic [15:0] pend, logic [1:0] cnt);
    vec_t v;
    v.alu_v = av;  v.alu.addr = aa;  v.alu.data = ad;
    v.ld_v  = lv;  v.ld.addr  = la;  v.ld.data  = ldd;
    v.e_ar  = ear; v.e_lr     = elr; v.e_we     = ewe;
    v.e_wr.addr = wa; v.e_wr.data = wd;
    v.e_pend = pend; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [3:0] la, input logic [31:0] ldd);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];

  initial begin
    // Expected values per cycle, sampled at the falling edge with that cycle's inputs applied.
    //             alu v/addr/data          ld v/addr/data        ar lr we wa   wd            pend     cnt
    tbl[0]  = mk(1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'h0,  1, 1, 0, 4'd0, 32'h0,        16'h0000, 2'd0);
    tbl[1]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 1, 4'd5, 32'hDEADBEEF, 16'h0000, 2'd0);
    tbl[2]  = mk(0, 4'd0, 32'h0,        1, 4'd3, 32'h12, 1, 1, 0, 4'd5, 32'hDEADBEEF, 16'h0000, 2'd0);
    tbl[3]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 0, 4'd5, 32'hDEADBEEF, 16'h0008, 2'd1);
    tbl[4]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 1, 4'd3, 32'h12,       16'h0000, 2'd0);
    tbl[5]  = mk(1, 4'd0, 32'hFF,       0, 4'd0, 32'h0,  1, 1, 0, 4'd3, 32'h12,       16'h0000, 2'd0);
    tbl[6]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 0, 4'd3, 32'h12,       16'h0000, 2'd0);
    tbl[7]  = mk(1, 4'd1, 32'h11,       1, 4'd2, 32'h22, 1, 1, 0, 4'd3, 32'h12,       16'h0000, 2'd0);
    tbl[8]  = mk(1, 4'd4, 32'h44,       1, 4'd6, 32'h66, 1, 1, 1, 4'd1, 32'h11,       16'h0004, 2'd1);
    tbl[9]  = mk(1, 4'd7, 32'h77,       1, 4'd9, 32'h99, 1, 0, 1, 4'd4, 32'h44,       16'h0044, 2'd2);
    tbl[10] = mk(0, 4'd0, 32'h0,        1, 4'd9, 32'h99, 1, 0, 1, 4'd7, 32'h77,       16'h0044, 2'd2);
    tbl[11] = mk(0, 4'd0, 32'h0,        1, 4'd9, 32'h99, 1, 1, 1, 4'd2, 32'h22,       16'h0040, 2'd1);
    tbl[12] = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 1, 4'd6, 32'h66,       16'h0200, 2'd1);
    tbl[13] = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 1, 4'd9, 32'h99,       16'h0000, 2'd0);
    tbl[14] = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  1, 1, 0, 4'd9, 32'h99,       16'h0000, 2'd0);

    rstn = 1'b0;
    set_in(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    next_cycle();
    chk("rst_wren",    WrEn,      0);
    chk("rst_wraddr",  WrAddr,    0);
    chk("rst_wrdata",  WrData,    0);
    chk("rst_pending", pending,   0);
    chk("rst_cnt",     fifo_cnt,  0);
    chk("rst_ldready", ld_ready,  1);
    chk("rst_alurdy",  alu_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].alu_v, tbl[i].alu.addr, tbl[i].alu.data,
             tbl[i].ld_v, tbl[i].ld.addr, tbl[i].ld.data);
      @(negedge clk);
      chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("v%0d_ld_ready", i),  ld_ready,  tbl[i].e_lr);
      chk($sformatf("v%0d_wren", i),      WrEn,      tbl[i].e_we);
      chk($sformatf("v%0d_wraddr", i),    WrAddr,    tbl[i].e_wr.addr);
      chk($sformatf("v%0d_wrdata", i),    WrData,    tbl[i].e_wr.data);
      chk($sformatf("v%0d_pending", i),   pending,   tbl[i].e_pend);
      chk($sformatf("v%0d_cnt", i),       fifo_cnt,  tbl[i].e_cnt);
      next_cycle();
    end

    // Starvation: one load buffered while the ALU stays busy.
    set_in(1, 4'd1, 32'h100, 1, 4'hA, 32'hAA);
    @(negedge clk);
    chk("stv0_alu_ready", alu_ready, 1);
    chk("stv0_cnt",       fifo_cnt,  0);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 4'd1, 32'h100, 0, 4'd0, 32'h0);
      @(negedge clk);
      chk($sformatf("stv%0d_alu_ready", i), alu_ready, (i == 4) ? 1'b0 : 1'b1);
      chk($sformatf("stv%0d_cnt", i),       fifo_cnt,  1);
      chk($sformatf("stv%0d_pending", i),   pending,   16'h0400);
      next_cycle();
    end
    @(negedge clk);
    chk("stv5_alu_ready", alu_ready, 1);
    chk("stv5_wren",      WrEn,      1);
    chk("stv5_wraddr",    WrAddr,    4'hA);
    chk("stv5_wrdata",    WrData,    32'hAA);
    chk("stv5_cnt",       fifo_cnt,  0);
    next_cycle();
    set_in(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(negedge clk);
    chk("stv6_wraddr", WrAddr, 4'd1);
    chk("stv6_wrdata", WrData, 32'h100);
    next_cycle();

    // Reset with a full buffer and a write in flight.
    set_in(1, 4'd1, 32'h5, 1, 4'hB, 32'hB);
    next_cycle();
    set_in(1, 4'd1, 32'h5, 1, 4'hC, 32'hC);
    next_cycle();
    set_in(1, 4'd1, 32'h5, 0, 4'd0, 32'h0);
    @(negedge clk);
    chk("mid_cnt",     fifo_cnt, 2);
    chk("mid_ldready", ld_ready, 0);
    chk("mid_pending", pending,  16'h1800);
    chk("mid_wren",    WrEn,     1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_cnt",     fifo_cnt,  0);
    chk("arst_pending", pending,   0);
    chk("arst_wren",    WrEn,      0);
    chk("arst_wraddr",  WrAddr,    0);
    chk("arst_ldready", ld_ready,  1);
    chk("arst_alurdy",  alu_ready, 1);
    set_in(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    next_cycle();
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post%0d_wren", i),    WrEn,     0);
      chk($sformatf("post%0d_cnt", i),     fifo_cnt, 0);
      chk($sformatf("post%0d_pending", i), pending,  0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, register-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register-data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of load-result buffer entries.
REQ-004 SHALL have parameter STARVE_MAX, default 3, consecutive cycles a buffered load may lose arbitration.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  in  1  reset; asynchronous assertion, active-low.
REQ-007 SHALL have ports alu_valid in 1 / alu_addr in ADDR_WIDTH / alu_data in DATA_WIDTH  ALU result.
REQ-008 SHALL have port alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
REQ-009 SHALL have ports ld_valid in 1 / ld_addr in ADDR_WIDTH / ld_data in DATA_WIDTH  load result.
REQ-010 SHALL have port ld_ready  out  1  load result accepted into buffer when high with ld_valid.
REQ-011 SHALL have ports WrEn out 1 / WrAddr out ADDR_WIDTH / WrData out DATA_WIDTH  register-file write port.
REQ-012 SHALL have port pending  out  2**ADDR_WIDTH  bit i high while any buffered load targets register i.
REQ-013 SHALL have port fifo_cnt  out  $clog2(FIFO_DEPTH+1)  current buffer occupancy.

Function
REQ-014 SHALL set ld_ready = (fifo_cnt < FIFO_DEPTH), independent of ld_valid.
REQ-015 SHALL push {ld_addr, ld_data} into the buffer on ld_valid && ld_ready; loads never bypass the buffer.
REQ-016 SHALL grant the write slot each cycle: starve-override pops the buffer, else ALU when alu_valid, else buffer head when non-empty, else idle.
REQ-017 SHALL set alu_ready = 1 except in a starve-override cycle.
REQ-018 SHALL register WrEn/WrAddr/WrData one cycle after the grant: ALU latency 1 cycle, minimum load latency 2 cycles (push N, pop N+1, WrEn high N+2).
REQ-019 SHALL force WrEn = 0 for a granted entry with address 0, while still consuming it (pop or alu_ready).
REQ-020 SHALL keep count unchanged on simultaneous push and pop; push at full is impossible by REQ-014.
REQ-021 SHALL count cycles buffer non-empty and head not popped; when count reaches STARVE_MAX, next cycle is a starve-override; count clears on any pop.
REQ-022 SHALL derive pending combinationally from valid buffer entries; pending[0] always 0.
REQ-023 SHALL NOT reorder buffered loads; ALU/load ordering to the same register is the issuer's responsibility via pending.
REQ-024 SHALL hold WrAddr/WrData at previous values when WrEn = 0.

Reset
REQ-025 SHALL on rstn low clear buffer, starve counter, WrEn, WrAddr, WrData, pending, fifo_cnt to 0; ld_ready = 1, alu_ready = 1.
REQ-026 SHALL discard buffered entries on reset mid-operation; no write issues in the first cycle after release.

Configuration
REQ-027 SHALL, with WB_BYPASS_EN defined, add outputs byp_valid(1)/byp_addr/byp_data, equal to the registered WrEn/WrAddr/WrData, for decode-operand forwarding.
REQ-028 SHALL, without WB_BYPASS_EN, omit those ports and all related logic.

Structure
REQ-029 SHALL place ADDR_WIDTH/DATA_WIDTH defaults and the wb_req_t struct {addr, data} in package wb_pkg.
REQ-030 SHALL implement the buffer as sub-module wb_fifo (push/pop/full/empty/count, entry array visible for pending).

Verification
REQ-031 ALU only: alu_valid=1, addr 5, data 0xDEADBEEF at N -> WrEn=1, WrAddr=5, WrData=0xDEADBEEF at N+1.
REQ-032 Load idle path: ld_valid, addr 3, data 0x12 at N, no ALU -> pending[3]=1 at N+1, WrEn addr 3 at N+2, pending[3]=0 at N+2.
REQ-033 Full: two loads pushed, ALU busy -> fifo_cnt=2, ld_ready=0; third load held until a pop.
REQ-034 Starvation: buffer non-empty, alu_valid stuck high -> after 3 lost cycles alu_ready=0 for one cycle and head written next cycle.
REQ-035 Address 0: ALU write addr 0 data 0xFF -> alu_ready=1, WrEn stays 0.
REQ-036 Reset mid-operation: rstn low with fifo_cnt=2 -> fifo_cnt=0, pending=0, WrEn=0 immediately; no stale write after release.
